// File: rtl/mio_riscv_tracer_pkg.sv
// Shared types and helpers for the RISC-V retirement tracer.
// Optional memory-access fields are present when MIO_RISCV_TRACER_MEM_EN is defined.
// Entry fields are sized for the widest supported XLEN (64). Narrower cores
// zero-extend into them, and the unused upper bits are trimmed at the outputs.
package mio_riscv_tracer_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int MAX_XLEN     = 64;
    localparam int MAX_ORDER_W  = 64;
    localparam int MAX_MASK_W   = MAX_XLEN / 8;

    typedef struct packed {
        logic [MAX_ORDER_W-1:0] order;
        logic [MAX_XLEN-1:0]    pc;
        logic [31:0]            insn;
        logic                   trap;
        logic [4:0]             rd_addr;
        logic [MAX_XLEN-1:0]    rd_wdata;
        logic [MAX_XLEN-1:0]    pc_wdata;
`ifdef MIO_RISCV_TRACER_MEM_EN
        logic [MAX_XLEN-1:0]    mem_addr;
        logic [MAX_MASK_W-1:0]  mem_rmask;
        logic [MAX_MASK_W-1:0]  mem_wmask;
        logic [MAX_XLEN-1:0]    mem_rdata;
        logic [MAX_XLEN-1:0]    mem_wdata;
`endif
    } mio_riscv_trace_entry_t;

    // RVFI zeroing: a trap kills the register write (and memory masks);
    // a write to x0 or an empty mask carries no data.
    function automatic mio_riscv_trace_entry_t normalise_entry(input mio_riscv_trace_entry_t e);
        mio_riscv_trace_entry_t n;
        n          = e;
        n.rd_addr  = e.trap ? 5'd0 : e.rd_addr;
        n.rd_wdata = (n.rd_addr == 5'd0) ? {MAX_XLEN{1'b0}} : e.rd_wdata;
`ifdef MIO_RISCV_TRACER_MEM_EN
        n.mem_rmask = e.trap ? {MAX_MASK_W{1'b0}} : e.mem_rmask;
        n.mem_wmask = e.trap ? {MAX_MASK_W{1'b0}} : e.mem_wmask;
        n.mem_rdata = (n.mem_rmask == {MAX_MASK_W{1'b0}}) ? {MAX_XLEN{1'b0}} : e.mem_rdata;
        n.mem_wdata = (n.mem_wmask == {MAX_MASK_W{1'b0}}) ? {MAX_XLEN{1'b0}} : e.mem_wdata;
`endif
        return n;
    endfunction

endpackage

// File: rtl/mio_riscv_tracer_fifo.sv
// Synchronous FIFO of trace entries with a registered head-of-queue output.
// The output register is loaded with the entry that will be at the head after
// each edge, so a fresh push is visible one cycle later and the output holds
// the last popped entry when the FIFO drains.
module mio_riscv_tracer_fifo
    import mio_riscv_tracer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  mio_riscv_trace_entry_t i_wdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_valid,
    output mio_riscv_trace_entry_t o_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mio_riscv_trace_entry_t r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_valid;
    mio_riscv_trace_entry_t r_rdata;

    logic                   w_push;
    logic                   w_pop;
    logic [PTR_W-1:0]       w_rptr_next;
    logic [CNT_W-1:0]       w_count_next;
    mio_riscv_trace_entry_t w_head_next;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_rdata = r_rdata;

    // Qualify requests and work out the head entry after this edge.
    always_comb begin
        w_pop        = i_pop & ~o_empty;
        w_push       = i_push & (~o_full | w_pop);
        w_rptr_next  = r_rptr + PTR_W'(w_pop);
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        // The pushed entry becomes the head only when it lands at the new read slot.
        if (w_push && (r_wptr == w_rptr_next)) begin
            w_head_next = i_wdata;
        end else begin
            w_head_next = r_mem[w_rptr_next];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers, occupancy and registered head output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            r_valid <= 1'b0;
            r_rdata <= {$bits(mio_riscv_trace_entry_t){1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1'b1);
            end
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
            r_valid <= (w_count_next != {CNT_W{1'b0}});
            if (w_count_next != {CNT_W{1'b0}}) begin
                r_rdata <= w_head_next;
            end
        end
    end

endmodule

// File: rtl/mio_riscv_retire_tracer.sv
// Retirement tracer producer: stamps order numbers, normalises to RVFI rules,
// buffers records and presents them on a valid/ready trace port.
// Define MIO_RISCV_TRACER_MEM_EN to carry memory-access fields as well.
module mio_riscv_retire_tracer
    import mio_riscv_tracer_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 64,
    parameter int DROP_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                retire_valid,
    input  logic [XLEN-1:0]     retire_pc,
    input  logic [31:0]         retire_insn,
    input  logic                retire_trap,
    input  logic [4:0]          retire_rd_addr,
    input  logic [XLEN-1:0]     retire_rd_wdata,
    input  logic [XLEN-1:0]     retire_next_pc,
`ifdef MIO_RISCV_TRACER_MEM_EN
    input  logic [XLEN-1:0]     retire_mem_addr,
    input  logic [XLEN/8-1:0]   retire_mem_rmask,
    input  logic [XLEN/8-1:0]   retire_mem_wmask,
    input  logic [XLEN-1:0]     retire_mem_rdata,
    input  logic [XLEN-1:0]     retire_mem_wdata,
`endif
    output logic                retire_stall,
    output logic                trace_valid,
    input  logic                trace_ready,
    output logic [ORDER_W-1:0]  trace_order,
    output logic [XLEN-1:0]     trace_pc,
    output logic [31:0]         trace_insn,
    output logic                trace_trap,
    output logic [4:0]          trace_rd_addr,
    output logic [XLEN-1:0]     trace_rd_wdata,
    output logic [XLEN-1:0]     trace_pc_wdata,
`ifdef MIO_RISCV_TRACER_MEM_EN
    output logic [XLEN-1:0]     trace_mem_addr,
    output logic [XLEN/8-1:0]   trace_mem_rmask,
    output logic [XLEN/8-1:0]   trace_mem_wmask,
    output logic [XLEN-1:0]     trace_mem_rdata,
    output logic [XLEN-1:0]     trace_mem_wdata,
`endif
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_count
);

    logic [ORDER_W-1:0]     r_order;
    logic [DROP_W-1:0]      r_drop_count;
    logic                   r_overflow;

    logic                   w_pop;
    logic                   w_push_ok;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_valid;
    logic [$clog2(DEPTH):0] w_count;
    mio_riscv_trace_entry_t w_entry_raw;
    mio_riscv_trace_entry_t w_entry;
    mio_riscv_trace_entry_t w_head;
    logic                   w_unused;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop     = w_valid & trace_ready;
    assign w_push_ok = retire_valid & (~w_full | w_pop);
    assign w_drop    = retire_valid & w_full & ~w_pop;

    // Stall depends only on registered occupancy, never on trace_ready.
    assign retire_stall = w_full;

    // Assemble the incoming record and apply the RVFI zeroing rules.
    always_comb begin
        w_entry_raw          = {$bits(mio_riscv_trace_entry_t){1'b0}};
        w_entry_raw.order    = MAX_ORDER_W'(r_order);
        w_entry_raw.pc       = MAX_XLEN'(retire_pc);
        w_entry_raw.insn     = retire_insn;
        w_entry_raw.trap     = retire_trap;
        w_entry_raw.rd_addr  = retire_rd_addr;
        w_entry_raw.rd_wdata = MAX_XLEN'(retire_rd_wdata);
        w_entry_raw.pc_wdata = MAX_XLEN'(retire_next_pc);
`ifdef MIO_RISCV_TRACER_MEM_EN
        w_entry_raw.mem_addr  = MAX_XLEN'(retire_mem_addr);
        w_entry_raw.mem_rmask = MAX_MASK_W'(retire_mem_rmask);
        w_entry_raw.mem_wmask = MAX_MASK_W'(retire_mem_wmask);
        w_entry_raw.mem_rdata = MAX_XLEN'(retire_mem_rdata);
        w_entry_raw.mem_wdata = MAX_XLEN'(retire_mem_wdata);
`endif
        w_entry = normalise_entry(w_entry_raw);
    end

    // Order counter advances only on accepted pushes; drops are counted and made sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_order      <= {ORDER_W{1'b0}};
            r_drop_count <= {DROP_W{1'b0}};
            r_overflow   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_order <= r_order + ORDER_W'(1'b1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != {DROP_W{1'b1}}) begin
                    r_drop_count <= r_drop_count + DROP_W'(1'b1);
                end
            end
        end
    end

    mio_riscv_tracer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_ok),
        .i_pop   (w_pop),
        .i_wdata (w_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_rdata (w_head)
    );

    assign trace_valid    = w_valid;
    assign trace_order    = w_head.order[ORDER_W-1:0];
    assign trace_pc       = w_head.pc[XLEN-1:0];
    assign trace_insn     = w_head.insn;
    assign trace_trap     = w_head.trap;
    assign trace_rd_addr  = w_head.rd_addr;
    assign trace_rd_wdata = w_head.rd_wdata[XLEN-1:0];
    assign trace_pc_wdata = w_head.pc_wdata[XLEN-1:0];
`ifdef MIO_RISCV_TRACER_MEM_EN
    assign trace_mem_addr  = w_head.mem_addr[XLEN-1:0];
    assign trace_mem_rmask = w_head.mem_rmask[XLEN/8-1:0];
    assign trace_mem_wmask = w_head.mem_wmask[XLEN/8-1:0];
    assign trace_mem_rdata = w_head.mem_rdata[XLEN-1:0];
    assign trace_mem_wdata = w_head.mem_wdata[XLEN-1:0];
`endif
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // Upper entry bits beyond XLEN/ORDER_W and spare FIFO status are intentionally unread.
    assign w_unused = ^{w_head, w_count, w_empty};

endmodule

// File: tb/tb_mio_riscv_retire_tracer.sv
// Self-checking bench for mio_riscv_retire_tracer (scoreboard plus vector table).
module tb_mio_riscv_retire_tracer;

    localparam int XLEN = 32, DEPTH = 8, ORDER_W = 64, DROP_W = 16;

    logic clk = 1'b0, reset = 1'b1;
    logic retire_valid = 1'b0, retire_trap = 1'b0, trace_ready = 1'b0;
    logic [31:0] retire_pc = '0, retire_insn = '0, retire_rd_wdata = '0, retire_next_pc = '0;
    logic [4:0]  retire_rd_addr = '0;
    logic retire_stall, trace_valid, trace_trap, overflow;
    logic [63:0] trace_order;
    logic [31:0] trace_pc, trace_insn, trace_rd_wdata, trace_pc_wdata;
    logic [4:0]  trace_rd_addr;
    logic [15:0] drop_count;
`ifdef MIO_RISCV_TRACER_MEM_EN
    logic [31:0] retire_mem_addr = '0, retire_mem_rdata = '0, retire_mem_wdata = '0;
    logic [3:0]  retire_mem_rmask = '0, retire_mem_wmask = '0;
    logic [31:0] trace_mem_addr, trace_mem_rdata, trace_mem_wdata;
    logic [3:0]  trace_mem_rmask, trace_mem_wmask;
`endif

    mio_riscv_retire_tracer #(.XLEN(XLEN), .DEPTH(DEPTH), .ORDER_W(ORDER_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_insn(retire_insn), .retire_trap(retire_trap), .retire_rd_addr(retire_rd_addr),
        .retire_rd_wdata(retire_rd_wdata), .retire_next_pc(retire_next_pc),
`ifdef MIO_RISCV_TRACER_MEM_EN
        .retire_mem_addr(retire_mem_addr), .retire_mem_rmask(retire_mem_rmask),
        .retire_mem_wmask(retire_mem_wmask), .retire_mem_rdata(retire_mem_rdata),
        .retire_mem_wdata(retire_mem_wdata),
`endif
        .retire_stall(retire_stall), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_order(trace_order), .trace_pc(trace_pc), .trace_insn(trace_insn),
        .trace_trap(trace_trap), .trace_rd_addr(trace_rd_addr), .trace_rd_wdata(trace_rd_wdata),
        .trace_pc_wdata(trace_pc_wdata),
`ifdef MIO_RISCV_TRACER_MEM_EN
        .trace_mem_addr(trace_mem_addr), .trace_mem_rmask(trace_mem_rmask),
        .trace_mem_wmask(trace_mem_wmask), .trace_mem_rdata(trace_mem_rdata),
        .trace_mem_wdata(trace_mem_wdata),
`endif
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] pcw;
`ifdef MIO_RISCV_TRACER_MEM_EN
        logic [31:0] maddr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic [31:0] mwdata;
`endif
    } exp_t;

    typedef struct {
        logic [31:0] pc, insn; logic trap; logic [4:0] rd; logic [31:0] wd, npc;
        logic [4:0] erd; logic [31:0] ewd;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    exp_t sb[$];
    exp_t pend, last, cur, act;
    logic [63:0] m_order = '0;
    logic [15:0] m_drops = '0;
    logic m_ovf = 1'b0, m_pop, m_full, m_acc, acc_flag = 1'b0, mon_en = 1'b0;

    task automatic chk(input string nm, input logic [319:0] a, input logic [319:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic exp_t get_act();
        exp_t a;
        a = '0;
        a.order = trace_order; a.pc = trace_pc; a.insn = trace_insn; a.trap = trace_trap;
        a.rd = trace_rd_addr; a.wdata = trace_rd_wdata; a.pcw = trace_pc_wdata;
`ifdef MIO_RISCV_TRACER_MEM_EN
        a.maddr = trace_mem_addr; a.rmask = trace_mem_rmask; a.wmask = trace_mem_wmask;
        a.rdata = trace_mem_rdata; a.mwdata = trace_mem_wdata;
`endif
        return a;
    endfunction

    // Scoreboard: check outputs against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = (sb.size() != 0) ? sb[0] : last;
            act = get_act();
            chk("record", 320'(act), 320'(cur));
            chk("valid", 320'(trace_valid), 320'(sb.size() != 0));
            chk("stall", 320'(retire_stall), 320'(sb.size() == DEPTH));
            chk("overflow", 320'(overflow), 320'(m_ovf));
            chk("drop_count", 320'(drop_count), 320'(m_drops));
            if (reset) begin
                sb.delete(); last = '0; m_order = '0; m_drops = '0; m_ovf = 1'b0; acc_flag = 1'b0;
            end else begin
                m_pop  = (sb.size() != 0) && trace_ready;
                m_full = (sb.size() == DEPTH);
                m_acc  = retire_valid && (!m_full || m_pop);
                if (m_pop) last = sb.pop_front();
                if (m_acc) begin
                    cur = pend; cur.order = m_order; m_order = m_order + 64'd1; sb.push_back(cur);
                end else if (retire_valid) begin
                    m_ovf = 1'b1;
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end
                acc_flag = m_acc;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_rec(input logic [31:0] pc, insn, input logic trap, input logic [4:0] rd,
                           input logic [31:0] wd, npc, input logic [4:0] erd, input logic [31:0] ewd);
        retire_pc = pc; retire_insn = insn; retire_trap = trap; retire_rd_addr = rd;
        retire_rd_wdata = wd; retire_next_pc = npc; retire_valid = 1'b1;
        pend = '0; pend.pc = pc; pend.insn = insn; pend.trap = trap; pend.rd = erd;
        pend.wdata = ewd; pend.pcw = npc;
`ifdef MIO_RISCV_TRACER_MEM_EN
        retire_mem_addr = '0; retire_mem_rmask = '0; retire_mem_wmask = '0;
        retire_mem_rdata = '0; retire_mem_wdata = '0;
`endif
    endtask

    task automatic put_simple(input int k);
        logic [4:0] rd;
        logic [31:0] wd;
        rd = 5'((k % 31) + 1);
        wd = 32'(32'hA000 + k);
        set_rec(32'(32'h1000 + 4 * k), 32'(32'h13 + k), 1'b0, rd, wd, 32'(32'h1004 + 4 * k), rd, wd);
    endtask

    task automatic gen_rand();
        logic t; logic [4:0] r; logic [31:0] w;
        t = ($urandom_range(0, 7) == 0);
        r = 5'($urandom_range(0, 31));
        w = $urandom;
        set_rec($urandom & 32'hFFFF_FFFC, $urandom, t, r, w, $urandom,
                t ? 5'd0 : r, (t || r == 5'd0) ? 32'd0 : w);
    endtask

    task automatic drain(input string nm);
        int g;
        retire_valid = 1'b0; trace_ready = 1'b1; g = 0;
        while (trace_valid && g < 50) begin step(); g++; end
        chk(nm, 320'(trace_valid), 320'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[4];
        int i, cyc;
        logic [15:0] drops_before;
        tv[0] = '{32'h200, 32'h13,       1'b0, 5'd0,  32'hDEAD,     32'h204,      5'd0,  32'h0};
        tv[1] = '{32'h204, 32'h73,       1'b1, 5'd5,  32'h1234,     32'h8000_0000, 5'd0,  32'h0};
        tv[2] = '{32'h208, 32'h00A00093, 1'b0, 5'd1,  32'hCAFE,     32'h20C,      5'd1,  32'hCAFE};
        tv[3] = '{32'h20C, 32'h0FF00F93, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h210,     5'd31, 32'hFFFF_FFFF};
        last = '0; pend = '0;

        // Reset state
        step(); step(); mon_en = 1'b1; step(); reset = 1'b0;
        chk("rst_valid", 320'(trace_valid), 320'(1'b0));
        chk("rst_order", 320'(trace_order), 320'(64'd0));
        chk("rst_pc", 320'(trace_pc), 320'(32'd0));
        chk("rst_stall", 320'(retire_stall), 320'(1'b0));

        // Three back-to-back retirements, one-cycle latency
        trace_ready = 1'b1;
        set_rec(32'h100, 32'h13, 1'b0, 5'd1, 32'h11, 32'h104, 5'd1, 32'h11); step();
        chk("t1_order0", 320'(trace_order), 320'(64'd0)); chk("t1_pc0", 320'(trace_pc), 320'(32'h100));
        set_rec(32'h104, 32'h13, 1'b0, 5'd2, 32'h22, 32'h108, 5'd2, 32'h22); step();
        chk("t1_order1", 320'(trace_order), 320'(64'd1)); chk("t1_pc1", 320'(trace_pc), 320'(32'h104));
        set_rec(32'h108, 32'h13, 1'b0, 5'd3, 32'h33, 32'h10C, 5'd3, 32'h33); step();
        chk("t1_order2", 320'(trace_order), 320'(64'd2)); chk("t1_pc2", 320'(trace_pc), 320'(32'h108));
        retire_valid = 1'b0; step();
        chk("t1_empty", 320'(trace_valid), 320'(1'b0));
        chk("t1_hold_pc", 320'(trace_pc), 320'(32'h108));

        // Normalisation table
        for (int k = 0; k < 4; k++) begin
            set_rec(tv[k].pc, tv[k].insn, tv[k].trap, tv[k].rd, tv[k].wd, tv[k].npc, tv[k].erd, tv[k].ewd);
            step();
            chk("norm_rd", 320'(trace_rd_addr), 320'(tv[k].erd));
            chk("norm_wdata", 320'(trace_rd_wdata), 320'(tv[k].ewd));
            chk("norm_pcw", 320'(trace_pc_wdata), 320'(tv[k].npc));
        end
        drain("t2_drain");

        // Overflow: DEPTH+2 retirements with consumer stalled
        reset = 1'b1; trace_ready = 1'b0; step(); reset = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin put_simple(k); step(); end
        retire_valid = 1'b0;
        chk("ovf_stall", 320'(retire_stall), 320'(1'b1));
        chk("ovf_flag", 320'(overflow), 320'(1'b1));
        chk("ovf_drops", 320'(drop_count), 320'(16'd2));
        chk("ovf_head", 320'(trace_order), 320'(64'd0));
        drain("t3_drain");
        put_simple(100); step();
        chk("ovf_next_order", 320'(trace_order), 320'(64'd8));
        drain("t3b_drain");

        // Full FIFO with simultaneous pop and push
        trace_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin put_simple(200 + k); step(); end
        retire_valid = 1'b0;
        chk("full_stall", 320'(retire_stall), 320'(1'b1));
        trace_ready = 1'b1; put_simple(300); step();
        chk("fullpush_stall", 320'(retire_stall), 320'(1'b1));
        chk("fullpush_drops", 320'(drop_count), 320'(16'd2));
        chk("fullpush_head", 320'(trace_order), 320'(64'd10));
        drain("t4_drain");

        // Random backpressure, core honours stall
        drops_before = drop_count;
        gen_rand(); i = 0; cyc = 0; retire_valid = !retire_stall; trace_ready = 1'b0;
        while (i < 1000 && cyc < 20000) begin
            step(); cyc++;
            if (acc_flag) begin i++; if (i < 1000) gen_rand(); end
            trace_ready = 1'($urandom_range(0, 1));
            retire_valid = (i < 1000) && !retire_stall;
        end
        chk("rand_retired", 320'(i), 320'(1000));
        drain("t5_drain");
        chk("rand_no_drop", 320'(drop_count), 320'(drops_before));
        chk("rand_order_next", 320'(m_order), 320'(64'd18 + 64'd1000));

        // Reset with records buffered
        trace_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin put_simple(400 + k); step(); end
        retire_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
        chk("mrst_valid", 320'(trace_valid), 320'(1'b0));
        chk("mrst_pc", 320'(trace_pc), 320'(32'd0));
        chk("mrst_ovf", 320'(overflow), 320'(1'b0));
        chk("mrst_drops", 320'(drop_count), 320'(16'd0));
        step();
        chk("mrst_quiet", 320'(trace_valid), 320'(1'b0));
        trace_ready = 1'b1; put_simple(500); step();
        chk("mrst_order0", 320'(trace_order), 320'(64'd0));
        chk("mrst_valid1", 320'(trace_valid), 320'(1'b1));
        drain("t6_drain");

`ifdef MIO_RISCV_TRACER_MEM_EN
        // Memory fields: trap clears masks; a zero mask clears its data
        set_rec(32'h600, 32'h23, 1'b1, 5'd0, 32'h0, 32'h604, 5'd0, 32'h0);
        retire_mem_addr = 32'h80; retire_mem_rmask = 4'h3; retire_mem_wmask = 4'hF;
        retire_mem_rdata = 32'h1234; retire_mem_wdata = 32'hDEAD_BEEF;
        pend.maddr = 32'h80;
        step();
        chk("mem_trap_wmask", 320'(trace_mem_wmask), 320'(4'h0));
        chk("mem_trap_wdata", 320'(trace_mem_wdata), 320'(32'h0));
        set_rec(32'h604, 32'h23, 1'b0, 5'd0, 32'h0, 32'h608, 5'd0, 32'h0);
        retire_mem_addr = 32'h84; retire_mem_rmask = 4'h0; retire_mem_wmask = 4'h3;
        retire_mem_rdata = 32'h7777; retire_mem_wdata = 32'h5555;
        pend.maddr = 32'h84; pend.wmask = 4'h3; pend.mwdata = 32'h5555;
        step();
        chk("mem_rdata_zero", 320'(trace_mem_rdata), 320'(32'h0));
        chk("mem_wdata_kept", 320'(trace_mem_wdata), 320'(32'h5555));
        drain("mem_drain");
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
